dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter and sequencer for the processor's 256 x 8 synchronous data memory. Shares the single memory port between the CPU load/store unit (port 0) and the program/debug loader (port 1). Uses round-robin priority, an optional per-port lock for atomic read-modify-write sequences, and a fixed one-cycle read-return path. Sits between the execute/memory stage, the loader and the data memory array.

## Interface
- ADDR_W, 8, memory address width (256 entries)
- DATA_W, 8, memory data width
- clk  in  1  sole clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- req0 / req1  in  1  access request, port 0 / port 1
- we0 / we1  in  1  1 = write, 0 = read
- lock0 / lock1  in  1  hold ownership after this grant
- addr0 / addr1  in  ADDR_W  access address
- wdata0 / wdata1  in  DATA_W  write data
- gnt0 / gnt1  out  1  one-cycle pulse; command issued to memory this cycle
- rvalid0 / rvalid1  out  1  read data valid for that port
- rdata  out  DATA_W  read data, shared; qualified by rvalid0/rvalid1
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en with mem_we = 0

## Operation
- Requester holds req, we, addr, wdata and lock stable from assertion until the cycle its gnt is high. gnt ends that request.
- The grant is combinational from the current-cycle req and state. mem_en, mem_we, mem_addr and mem_wdata are driven combinationally from the granted port in the same cycle. With no grant, mem_en = mem_we = 0 and addr/wdata = 0.
- At most one gnt per cycle. Back-to-back grants every cycle are allowed (pipelined).
- Round-robin pointer `last`: when both ports request in ARB, grant the port not equal to `last`. After every grant, `last` = granted port. Reset value of `last` = 1, so port 0 wins the first tie.
- Lock FSM, states ARB, LOCK0, LOCK1:
  - ARB: normal arbitration. Granting port p with lockp = 1 moves to LOCKp.
  - LOCKp: only port p may be granted; the other port's req is ignored. lockp = 0 in any cycle returns to ARB next cycle. A grant in that same cycle is still honoured.
  - Lock asserted without a grant has no effect.
- Writes produce no rvalid.
- A read granted in cycle N raises rvalidp in cycle N+1, with rdata = mem_rdata. With no rvalid, rdata = 0.
- Only an owner tag (port, valid) is registered for the return path. Data is not buffered.

## Timing
- Reset values: gnt0/1 = 0, rvalid0/1 = 0, rdata = 0, all mem_* = 0, state = ARB, `last` = 1, read tag invalid.
- Grant latency: 0 cycles from req when the port wins. Read latency: 1 cycle from gnt to rvalid.
- Reset asserted mid-operation: any in-flight read tag is discarded, so no rvalid after reset release. The lock is released.
- Write at N then read of the same address at N+1 returns the new data, per memory write-before-read.
- Simultaneous lock release and other-port request: the other port is not granted that cycle; it is eligible next cycle.

## Configuration
- DMEM_ARB_STATS_EN defined:
  - Adds outputs stall0 and stall1 (16 bits each).
  - Each is a saturating count of cycles with reqp = 1 and gntp = 0.
  - Reset to 0; held at 16'hFFFF on saturation.
- Not defined: ports and counters absent. Arbitration behaviour is identical.

## Structure
- Shared package dmem_pkg: ADDR_W, DATA_W, state enum (ARB, LOCK0, LOCK1), port index constants PORT_CPU = 0, PORT_LDR = 1.
- One sub-module: dmem_rr_pick. It is a combinational two-way round-robin select over req0, req1, `last` and state mask, and outputs a one-hot grant.

## Test plan
- Reset, then req0 read addr 0x10 (memory holds 0x5A) -> gnt0 in same cycle; rvalid0 = 1 and rdata = 0x5A next cycle.
- req0 and req1 both held for 4 cycles (reads) -> grants alternate 0,1,0,1; each rvalid follows its grant by 1 cycle.
- Port 1 write 0x33 to 0x80 with lock1 = 1, then port 1 read 0x80 with lock1 = 0 while req0 held -> gnt1, gnt1, then gnt0. rvalid1 carries 0x33.
- Read granted to port 0, rst pulsed in the following cycle -> no rvalid0. All outputs 0; the next tie goes to port 0.
- Write 0xC4 to 0xFF, read 0xFF in the next cycle -> rdata = 0xC4, no rvalid for the write cycle.
- With DMEM_ARB_STATS_EN: port 1 locked for 5 cycles while req0 is held -> stall0 = 5, stall1 = 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory arbiter slice: memory geometry,
// lock FSM state encoding, port index constants and the stall counter width.
// -----------------------------------------------------------------------------
package dmem_pkg;

  localparam int ADDR_W  = 8;   // 256-entry data memory
  localparam int DATA_W  = 8;
  localparam int STALL_W = 16;  // width of the optional stall counters

  // Port indices; also the encoding of the round-robin `last` pointer.
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  // ARB: free arbitration. LOCKp: port p owns the memory until it drops lockp.
  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

endpackage : dmem_pkg

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles both requester ports and the memory-side port of the arbiter.
//   slave  : arbiter view (requests and mem_rdata in; grants, read return,
//            memory command out)
//   master : environment view (requesters plus the memory array)
// Signals per requester p in {0,1}: reqp, wep, lockp, addrp, wdatap, gntp,
// rvalidp. Shared: rdata. Memory: mem_en, mem_we, mem_addr, mem_wdata,
// mem_rdata.
// -----------------------------------------------------------------------------
interface dmem_arbiter_if
  import dmem_pkg::*;
;

  logic              req0,   req1;
  logic              we0,    we1;
  logic              lock0,  lock1;
  logic [ADDR_W-1:0] addr0,  addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0,   gnt1;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, lock0, lock1,
           addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req0, req1, we0, we1, lock0, lock1,
           addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface : dmem_arbiter_if

// File: rtl/dmem_rr_pick.sv
// -----------------------------------------------------------------------------
// dmem_rr_pick
// Combinational two-way round-robin select.
//   req   [1:0] in  raw requests, bit p = port p
//   allow [1:0] in  state mask; a port whose bit is 0 cannot be granted
//   last        in  port granted most recently (loses a tie)
//   gnt   [1:0] out one-hot grant, or 0 when nothing is eligible
// -----------------------------------------------------------------------------
module dmem_rr_pick
  import dmem_pkg::*;
(
  input  logic [1:0] req,
  input  logic [1:0] allow,
  input  logic       last,
  output logic [1:0] gnt
);

  logic [1:0] elig;

  assign elig = req & allow;

  // NOTE: every output of an always_comb gets a default before the case so no
  // path leaves it unassigned; otherwise a latch is inferred.
  always_comb begin
    gnt = 2'b00;
    unique case (elig)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == PORT_CPU) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule : dmem_rr_pick

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single port of the 256 x 8 synchronous data memory between the
// CPU load/store unit (port 0) and the program/debug loader (port 1).
//   clk, rst  : sole clock; asynchronous active-high reset
//   bus       : dmem_arbiter_if.slave -- both requesters and the memory port
//   stall0/1  : (DMEM_ARB_STATS_EN only) saturating 16-bit counts of cycles a
//               port requested without being granted
//
// Grants are combinational from this cycle's requests; the memory command is
// muxed from the granted port in the same cycle. Round-robin on ties, with a
// per-port lock that hands a requester exclusive ownership for atomic
// read-modify-write. Read data is not buffered: only an owner tag is
// registered, and rdata is mem_rdata qualified by that tag one cycle later.
//
// Optional feature macro: DMEM_ARB_STATS_EN (adds stall0/stall1).
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  dmem_arbiter_if.slave       bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [STALL_W-1:0]  stall0,
  output logic [STALL_W-1:0]  stall1
`endif
);

  arb_state_e        state;
  logic              last;       // port granted most recently
  logic              tag_valid;  // a read was issued last cycle
  logic              tag_port;   // which port that read belongs to

  logic [1:0]        allow;
  logic [1:0]        gnt_oh;
  logic              sel_en;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Lock state masks the non-owner. Held in reset the mask is empty so no
  // command can reach the memory while the arbiter is being cleared.
  always_comb begin
    allow = 2'b00;
    if (!rst) begin
      unique case (state)
        LOCK0:   allow = 2'b01;
        LOCK1:   allow = 2'b10;
        default: allow = 2'b11;
      endcase
    end
  end

  dmem_rr_pick u_pick (
    .req   ({bus.req1, bus.req0}),
    .allow (allow),
    .last  (last),
    .gnt   (gnt_oh)
  );

  // Memory command mux: idle port drives all-zero.
  always_comb begin
    sel_en    = 1'b0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (gnt_oh[0]) begin
      sel_en    = 1'b1;
      sel_we    = bus.we0;
      sel_addr  = bus.addr0;
      sel_wdata = bus.wdata0;
    end else if (gnt_oh[1]) begin
      sel_en    = 1'b1;
      sel_we    = bus.we1;
      sel_addr  = bus.addr1;
      sel_wdata = bus.wdata1;
    end
  end

  assign bus.gnt0      = gnt_oh[0];
  assign bus.gnt1      = gnt_oh[1];
  assign bus.mem_en    = sel_en;
  assign bus.mem_we    = sel_we;
  assign bus.mem_addr  = sel_addr;
  assign bus.mem_wdata = sel_wdata;

  // Read return: the memory presents data one cycle after the read command,
  // so the registered tag lines up with mem_rdata without any data register.
  assign bus.rvalid0 = tag_valid && (tag_port == PORT_CPU);
  assign bus.rvalid1 = tag_valid && (tag_port == PORT_LDR);
  assign bus.rdata   = tag_valid ? bus.mem_rdata : '0;

  // Lock FSM, round-robin pointer and read tag.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ARB;
      last      <= PORT_LDR;  // port 0 wins the first tie
      tag_valid <= 1'b0;
      tag_port  <= PORT_CPU;
    end else begin
      tag_valid <= sel_en && !sel_we;
      tag_port  <= gnt_oh[1];
      if (sel_en) begin
        last <= gnt_oh[1];
      end
      unique case (state)
        ARB: begin
          if (gnt_oh[0] && bus.lock0)      state <= LOCK0;
          else if (gnt_oh[1] && bus.lock1) state <= LOCK1;
        end
        // Release takes effect next cycle; a grant in the release cycle still
        // went to the owner because the mask was applied this cycle.
        LOCK0:   if (!bus.lock0) state <= ARB;
        LOCK1:   if (!bus.lock1) state <= ARB;
        default: state <= ARB;
      endcase
    end
  end

`ifdef DMEM_ARB_STATS_EN
  // Saturating stall counters: cycles with a request but no grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall0 <= '0;
      stall1 <= '0;
    end else begin
      if (bus.req0 && !gnt_oh[0] && (stall0 != {STALL_W{1'b1}}))
        stall0 <= stall0 + STALL_W'(1);
      if (bus.req1 && !gnt_oh[1] && (stall1 != {STALL_W{1'b1}}))
        stall1 <= stall1 + STALL_W'(1);
    end
  end
`endif

endmodule : dmem_arbiter
